flopr_sync: RTL and testbench



---
 rtl/flopr_sync.sv | 58 +++++
 tb/tb_flopr_sync.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/flopr_sync.sv
// Resettable register / short register pipeline clocked on ph1 with synchronous reset.
// Optional X/Z checker on d and RESET_VAL when FLOPR_XCHECK_EN is defined (simulation only).
module flopr_sync #(
  parameter int              WIDTH     = 2,
  parameter int              STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || STAGES < 1) begin : g_param_err
    $error("flopr_sync: WIDTH (%0d) and STAGES (%0d) must both be >= 1", WIDTH, STAGES);
  end

  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  // ph2 exists only so legacy two-phase instantiations still connect.
  logic unused_ph2;
  assign unused_ph2 = ph2;

  always_comb begin
    s_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      s_d[i] = s_q[i-1];
    end
  end

  always_ff @(posedge ph1) begin
    for (int i = 0; i < STAGES; i++) begin
      if (reset) begin
        s_q[i] <= RESET_VAL;
      end else begin
        s_q[i] <= s_d[i];
      end
    end
  end

  assign q = s_q[STAGES-1];

`ifdef FLOPR_XCHECK_EN
  always @(posedge ph1) begin
    if (!reset && $isunknown(d)) begin
      $error("%m: X/Z on d (%b) at time %0t", d, $time);
    end
    if (reset && $isunknown(RESET_VAL)) begin
      $error("%m: RESET_VAL contains X/Z (%b) at time %0t", RESET_VAL, $time);
    end
  end
`else
  // Checker compiled out; datapath above is identical in both builds.
`endif

endmodule

// File: tb/tb_flopr_sync.sv
// Scoreboard bench for flopr_sync: a 2-bit single-stage instance and an 8-bit 3-stage instance.
// A queue-based reference model pushes expected q values; a monitor pops and compares after each edge.
module tb_flopr_sync;

  localparam logic [1:0] A_RST = 2'b00;
  localparam logic [7:0] B_RST = 8'hA5;

  logic       ph1 = 1'b0;
  logic       ph2 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] da = 2'b00;
  logic [7:0] db = 8'h00;
  logic [1:0] q_a;
  logic [7:0] q_b;
  logic       clk_run = 1'b1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] hist_a[$];
  logic [7:0] hist_b[$];
  logic [1:0] last_a;
  logic [7:0] last_b;
  bit         started = 1'b0;

  flopr_sync #(.WIDTH(2), .STAGES(1), .RESET_VAL(A_RST)) dut_a (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(da), .q(q_a)
  );

  flopr_sync #(.WIDTH(8), .STAGES(3), .RESET_VAL(B_RST)) dut_b (
    .ph1(ph1), .ph2(ph2), .reset(reset), .d(db), .q(q_b)
  );

  always begin
    #5;
    if (clk_run) ph1 = ~ph1;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One call covers exactly one ph1 rising edge with the given inputs.
  task automatic applyStimulus(input logic r, input logic [1:0] a, input logic [7:0] b);
    reset = r;
    da    = a;
    db    = b;
    ph2   = 1'($urandom);
    @(negedge ph1);
  endtask

  // Reference model: each output is the input from STAGES edges back, or RESET_VAL if a reset intervened.
  always @(posedge ph1) begin
    if (reset) begin
      started = 1'b1;
      hist_a  = {A_RST};
      hist_b  = {B_RST, B_RST, B_RST};
    end else if (started) begin
      hist_a.push_back(da);
      void'(hist_a.pop_front());
      hist_b.push_back(db);
      void'(hist_b.pop_front());
    end
    if (started) begin
      last_a = hist_a[0];
      last_b = hist_b[0];
      exp_q.push_back('{a: hist_a[0], b: hist_b[0]});
    end
  end

  always @(posedge ph1) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("q_a", {6'b0, q_a}, {6'b0, e.a});
      checkOutput("q_b", q_b, e.b);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 2'b11, 8'h55);
    applyStimulus(1'b0, 2'b01, 8'h10);
    applyStimulus(1'b0, 2'b10, 8'h20);

    repeat (3) applyStimulus(1'b1, 2'b10, 8'($urandom));
    applyStimulus(1'b0, 2'b10, 8'h30);

    applyStimulus(1'b0, 2'b11, 8'h40);
    reset = 1'b1;
    #2;
    checkOutput("sync_reset_hold", {6'b0, q_a}, 8'h03);
    applyStimulus(1'b1, 2'b01, 8'h00);

    applyStimulus(1'b0, 2'b00, 8'h01);
    applyStimulus(1'b0, 2'b01, 8'h02);
    applyStimulus(1'b0, 2'b10, 8'h03);
    applyStimulus(1'b0, 2'b11, 8'h04);
    applyStimulus(1'b0, 2'b00, 8'h05);

    applyStimulus(1'b0, 2'b01, 8'hC1);
    applyStimulus(1'b0, 2'b10, 8'hC2);
    applyStimulus(1'b1, 2'b11, 8'hC3);
    repeat (4) applyStimulus(1'b0, 2'($urandom), 8'($urandom));

    // Freeze ph1 low and wiggle ph2; q must not move.
    clk_run = 1'b0;
    repeat (21) begin
      #3;
      ph2 = 1'($urandom);
      da  = 2'($urandom);
      db  = 8'($urandom);
      #0;
      checkOutput("ph2_hold_a", {6'b0, q_a}, {6'b0, last_a});
      checkOutput("ph2_hold_b", q_b, last_b);
    end
    clk_run = 1'b1;

    repeat (300) applyStimulus(($urandom_range(0, 15) == 0), 2'($urandom), 8'($urandom));

    reset = 1'b0;
    repeat (2) @(negedge ph1);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
